sha3_msg_feeder: RTL and testbench

Front end for the SHA3 core. It takes a 64-bit little-endian message stream and packs it into rate-sized blocks for the selected mode. It applies SHA3 padding (domain byte DS_BYTE, final 0x80), issues one block at a time to the core, waits for the core's done, and returns the digest with a valid/ready handshake.

---
 rtl/sha3_msg_feeder.sv | 190 +++++++++++++++++++
 tb/tb_sha3_msg_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_msg_feeder.sv
// SHA3 front end: packs a 64-bit little-endian stream into rate blocks, pads, drives the core, returns the digest.
// Optional: define SHA3_FEEDER_MSGLEN_EN to add the msg_len accepted-byte counter output.
module sha3_msg_feeder #(
  parameter logic [7:0]  DS_BYTE   = 8'h06,
  parameter int unsigned MAX_WORDS = 18
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mode,
  input  logic [63:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [2:0]              s_bytes,
  output logic [MAX_WORDS*64-1:0] core_block,
  output logic [1:0]              core_mode,
  output logic                    core_first,
  output logic                    core_final,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [511:0]            core_digest,
  output logic [511:0]            digest,
  output logic                    digest_valid,
  input  logic                    digest_ready
`ifdef SHA3_FEEDER_MSGLEN_EN
  ,
  output logic [31:0]             msg_len
`endif
);

  localparam int unsigned NB = MAX_WORDS * 8;
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned PW = CW + 3;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [MAX_WORDS*64-1:0] r_buf, w_pad_blk;
  logic [CW-1:0]           r_cnt, w_rate;
  logic [PW-1:0]           r_padpos, w_last_byte;
  logic [1:0]              r_mode, w_mode;
  logic                    r_first, r_final, r_pad_pending, r_s_ready;
  logic [511:0]            r_digest;
  logic [3:0]              w_nbytes;
  logic [63:0]             w_word;
  logic                    w_accept, w_blk_end, w_full_last;

  assign w_mode      = (r_state == S_IDLE) ? mode : r_mode;
  assign w_nbytes    = (!s_last || s_bytes == 3'd0) ? 4'd8 : {1'b0, s_bytes};
  assign w_accept    = s_valid & r_s_ready;
  assign w_blk_end   = (r_cnt == w_rate - 1'b1);
  assign w_full_last = s_last && w_blk_end && (w_nbytes == 4'd8);
  assign w_last_byte = {w_rate - 1'b1, 3'b111};

  always_comb begin
    case (w_mode)
      2'b00:   w_rate = CW'(9);
      2'b01:   w_rate = CW'(13);
      2'b11:   w_rate = CW'(17);
      default: w_rate = CW'(18);
    endcase
  end

  // Lanes beyond the valid byte count of a final word never reach the buffer.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(i) < w_nbytes) w_word[8*i +: 8] = s_data[8*i +: 8];
    end
  end

  // r_padpos is 0 for the trailing pad-only block, so one path covers both cases.
  always_comb begin
    w_pad_blk = r_buf;
    for (int unsigned b = 0; b < NB; b++) begin
      if (32'(r_padpos) == b)    w_pad_blk[8*b +: 8] = w_pad_blk[8*b +: 8] | DS_BYTE;
      if (32'(w_last_byte) == b) w_pad_blk[8*b +: 8] = w_pad_blk[8*b +: 8] | 8'h80;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_accept) begin
          if (w_full_last)    w_state_nxt = S_ISSUE;
          else if (s_last)    w_state_nxt = S_PAD;
          else if (w_blk_end) w_state_nxt = S_ISSUE;
          else                w_state_nxt = S_FILL;
        end
      end
      S_PAD:   w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          if (r_final)            w_state_nxt = S_OUT;
          else if (r_pad_pending) w_state_nxt = S_PAD;
          else                    w_state_nxt = S_FILL;
        end
      end
      S_OUT:   if (digest_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_padpos      <= '0;
      r_mode        <= '0;
      r_first       <= 1'b0;
      r_final       <= 1'b0;
      r_pad_pending <= 1'b0;
      r_s_ready     <= 1'b0;
      r_digest      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FILL);
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_accept) begin
            r_buf[{r_cnt, 6'b0} +: 64] <= w_word;
            r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE) begin
              r_mode  <= mode;
              r_first <= 1'b1;
            end
            if (w_full_last) r_pad_pending <= 1'b1;
            if (s_last) r_padpos <= w_full_last ? '0 : PW'({r_cnt, 3'b000}) + PW'(w_nbytes);
          end
        end
        S_PAD: begin
          r_buf         <= w_pad_blk;
          r_final       <= 1'b1;
          r_pad_pending <= 1'b0;
        end
        S_WAIT: begin
          if (core_done) begin
            if (r_final) begin
              r_digest <= core_digest;
            end else begin
              r_buf   <= '0;
              r_cnt   <= '0;
              r_first <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (digest_ready) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_final <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign core_block   = r_buf;
  assign core_mode    = r_mode;
  assign core_first   = r_first;
  assign core_final   = r_final;
  assign core_start   = (r_state == S_ISSUE);
  assign digest       = r_digest;
  assign digest_valid = (r_state == S_OUT);

`ifdef SHA3_FEEDER_MSGLEN_EN
  logic [31:0] r_len;
  logic [32:0] w_len_sum;

  assign w_len_sum = {1'b0, r_len} + 33'(w_nbytes);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) r_len <= 32'(w_nbytes);
      else                   r_len <= w_len_sum[32] ? '1 : w_len_sum[31:0];
    end
  end

  assign msg_len = r_len;
`endif

endmodule

// File: tb/tb_sha3_msg_feeder.sv
// Bench for sha3_msg_feeder: directed and random messages against a SHA3 padding model and a stub core.
`timescale 1ns/1ps
module tb_sha3_msg_feeder;
  localparam int unsigned MW = 18;

  typedef byte unsigned bq_t[$];

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [63:0]    s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic           s_last = 1'b0;
  logic [2:0]     s_bytes = 3'd0;
  logic [MW*64-1:0] core_block;
  logic [1:0]     core_mode;
  logic           core_first, core_final, core_start;
  logic           core_done = 1'b0;
  logic [511:0]   core_digest = '0;
  logic [511:0]   digest;
  logic           digest_valid;
  logic           digest_ready = 1'b0;
`ifdef SHA3_FEEDER_MSGLEN_EN
  logic [31:0]    msg_len;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sha3_msg_feeder #(.DS_BYTE(8'h06), .MAX_WORDS(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mode         (mode),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .s_bytes      (s_bytes),
    .core_block   (core_block),
    .core_mode    (core_mode),
    .core_first   (core_first),
    .core_final   (core_final),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_digest  (core_digest),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready)
`ifdef SHA3_FEEDER_MSGLEN_EN
    ,
    .msg_len      (msg_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned rate_words(input logic [1:0] m);
    case (m)
      2'b00:   return 9;
      2'b01:   return 13;
      2'b11:   return 17;
      default: return 18;
    endcase
  endfunction

  task automatic fill_msg(output bq_t q, input int unsigned n);
    q.delete();
    for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_s_ready"}, 576'(s_ready), 576'(0));
    check_eq({pfx, "_core_start"}, 576'(core_start), 576'(0));
    check_eq({pfx, "_digest_valid"}, 576'(digest_valid), 576'(0));
    check_eq({pfx, "_digest"}, 576'(digest), 576'(0));
    check_eq({pfx, "_blk_lo"}, core_block[575:0], 576'(0));
    check_eq({pfx, "_blk_hi"}, core_block[1151:576], 576'(0));
    check_eq({pfx, "_first"}, 576'(core_first), 576'(0));
    check_eq({pfx, "_final"}, 576'(core_final), 576'(0));
    check_eq({pfx, "_mode"}, 576'(core_mode), 576'(0));
`ifdef SHA3_FEEDER_MSGLEN_EN
    check_eq({pfx, "_msg_len"}, 576'(msg_len), 576'(0));
`endif
  endtask

  // Drives one message, plays the core, checks every issued block and the returned digest.
  task automatic run_msg(input logic [1:0] m, input bq_t msg, input bit toggle,
                         input bit abort, input int unsigned hold_cyc);
    logic [MW*64-1:0] exp_blk[$];
    logic [MW*64-1:0] blk;
    logic [511:0]     exp_dig;
    byte unsigned     pad[];
    logic [63:0]      w;
    int unsigned      len, rb, nblk, nw, beat, blk_seen, done_dly, cyc, hold, nb;
    bit               outstanding, fin, released, dig_seen, abort_now, stray_start;

    len  = msg.size();
    rb   = 8 * rate_words(m);
    nblk = len / rb + 1;
    pad  = new[nblk * rb];
    foreach (pad[i]) pad[i] = 8'h00;
    foreach (msg[i]) pad[i] = msg[i];
    pad[len]         = pad[len] | 8'h06;
    pad[nblk*rb - 1] = pad[nblk*rb - 1] | 8'h80;
    for (int unsigned b = 0; b < nblk; b++) begin
      blk = '0;
      for (int unsigned j = 0; j < rb; j++) blk[8*j +: 8] = pad[b*rb + j];
      exp_blk.push_back(blk);
    end
    for (int unsigned i = 0; i < 16; i++) exp_dig[32*i +: 32] = $urandom;

    nw = (len + 7) / 8;
    beat = 0; blk_seen = 0; done_dly = 0; cyc = 0; hold = hold_cyc;
    outstanding = 1'b0; fin = 1'b0; released = 1'b0; dig_seen = 1'b0; abort_now = 1'b0;
    mode = m;

    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b0; core_done = 1'b0; digest_ready = 1'b0;
      if (released) begin
        check_eq("dv_drop", 576'(digest_valid), 576'(0));
        check_eq("rdy_after_out", 576'(s_ready), 576'(1));
        check_eq("n_blocks", 576'(blk_seen), 576'(nblk));
        fin = 1'b1;
      end else if (abort_now) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        stray_start = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (core_start) stray_start = 1'b1;
        end
        check_eq("no_start_after_rst", 576'(stray_start), 576'(0));
        check_eq("rdy_after_rst", 576'(s_ready), 576'(1));
        check_eq("dv_after_rst", 576'(digest_valid), 576'(0));
        fin = 1'b1;
      end else begin
        if (core_start) begin
          check_eq("start_expected", 576'(blk_seen < nblk), 576'(1));
          check_eq("rdy_issue", 576'(s_ready), 576'(0));
          if (blk_seen < nblk) begin
            check_eq("blk_lo", core_block[575:0], exp_blk[blk_seen][575:0]);
            check_eq("blk_hi", core_block[1151:576], exp_blk[blk_seen][1151:576]);
            check_eq("first", 576'(core_first), 576'(blk_seen == 0));
            check_eq("final", 576'(core_final), 576'(blk_seen == nblk - 1));
            check_eq("core_mode", 576'(core_mode), 576'(m));
          end
          blk_seen++;
          outstanding = 1'b1;
          done_dly = $urandom_range(1, 4);
          abort_now = abort;
        end else if (outstanding) begin
          done_dly--;
          if (done_dly == 0) begin
            if (blk_seen <= nblk) begin
              check_eq("blk_stable_lo", core_block[575:0], exp_blk[blk_seen-1][575:0]);
              check_eq("blk_stable_hi", core_block[1151:576], exp_blk[blk_seen-1][1151:576]);
            end
            for (int unsigned i = 0; i < 16; i++) core_digest[32*i +: 32] = $urandom;
            if (blk_seen == nblk) core_digest = exp_dig;
            core_done = 1'b1;
            outstanding = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          for (int unsigned i = 0; i < 16; i++) core_digest[32*i +: 32] = $urandom;
          core_done = 1'b1;
        end

        if (toggle && beat > 0) mode = m ^ 2'b10;
        if (beat < nw && $urandom_range(0, 3) != 0) begin
          w = {$urandom, $urandom};
          for (int unsigned j = 0; j < 8; j++)
            if (8*beat + j < len) w[8*j +: 8] = msg[8*beat + j];
          nb      = len - 8*beat;
          s_data  = w;
          s_last  = (beat == nw - 1);
          s_bytes = (nb >= 8) ? 3'd0 : 3'(nb);
          s_valid = 1'b1;
          if (s_ready) beat++;
        end

        if (digest_valid) begin
          if (!dig_seen) begin
            check_eq("digest", 576'(digest), 576'(exp_dig));
            check_eq("blocks_before_digest", 576'(blk_seen), 576'(nblk));
`ifdef SHA3_FEEDER_MSGLEN_EN
            check_eq("msg_len", 576'(msg_len), 576'(len));
`endif
            dig_seen = 1'b1;
          end else begin
            check_eq("digest_hold", 576'(digest), 576'(exp_dig));
          end
          check_eq("rdy_in_out", 576'(s_ready), 576'(0));
          if (hold == 0) begin
            digest_ready = 1'b1;
            released = 1'b1;
          end else begin
            hold--;
          end
        end
      end
    end
    s_valid = 1'b0; core_done = 1'b0; digest_ready = 1'b0;
    if (!fin) check_eq("timeout", 576'(0), 576'(1));
  endtask

  initial begin
    bq_t q;
    reset_n = 1'b0;
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_idle", 576'(s_ready), 576'(1));

    q.delete();
    q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
    run_msg(2'b11, q, 1'b0, 1'b0, 0);
    fill_msg(q, 136); run_msg(2'b11, q, 1'b0, 1'b0, 2);
    fill_msg(q, 135); run_msg(2'b11, q, 1'b0, 1'b0, 1);
    fill_msg(q, 160); run_msg(2'b00, q, 1'b1, 1'b0, 10);
    fill_msg(q, 50);  run_msg(2'b01, q, 1'b0, 1'b1, 0);
    fill_msg(q, 72);  run_msg(2'b00, q, 1'b0, 1'b0, 0);
    fill_msg(q, 71);  run_msg(2'b00, q, 1'b0, 1'b0, 3);
    fill_msg(q, 144); run_msg(2'b10, q, 1'b0, 1'b0, 0);
    fill_msg(q, 1);   run_msg(2'b10, q, 1'b0, 1'b0, 0);
    fill_msg(q, 104); run_msg(2'b01, q, 1'b0, 1'b0, 0);
    repeat (20) begin
      fill_msg(q, $urandom_range(1, 300));
      run_msg(2'($urandom_range(0, 3)), q, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 10));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
